// File: rtl/avl_mem_responder.sv
// Memory-side Avalon-MM burst responder: wrapping on-chip storage, write bursts with stalls,
// and fixed-latency read bursts with one burst outstanding at a time.
module avl_mem_responder #(
    parameter int DATA_W       = 128,
    parameter int ADDR_W       = 26,
    parameter int DEPTH_LOG2   = 8,
    parameter int READ_LATENCY = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] AVL_ADDRESS,
    input  logic              AVL_BEGIN,
    input  logic [8:0]        AVL_COUNT,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [DATA_W-1:0] AVL_WDATA,
    output logic [DATA_W-1:0] AVL_RDATA,
    output logic              AVL_WAIT,
    output logic              AVL_RDATA_VALID
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_ISSUE = 4'(READ_LATENCY - 2);
    localparam logic [3:0] LAT_LAST  = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_LAT, RD_BURST} state_t;

    state_t                r_state, w_state_next;
    logic [DEPTH_LOG2-1:0] r_addr, w_addr_next;
    logic [8:0]            r_count, w_count_next;
    logic [8:0]            r_beat, w_beat_next;
    logic [8:0]            r_issue, w_issue_next;
    logic [3:0]            r_lat, w_lat_next;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DATA_W-1:0]     r_mem_q;
    logic                  r_q_vld;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_rdata_valid;

    logic [8:0]            w_cnt_eff;
    logic                  w_accept;
    logic                  w_we;
    logic                  w_re;
    logic [DEPTH_LOG2-1:0] w_widx;
    logic [DEPTH_LOG2-1:0] w_ridx;
    logic                  w_unused_addr;

    // Only the low DEPTH_LOG2 address bits select storage.
    assign w_unused_addr = ^AVL_ADDRESS;

    always_comb begin
        if (AVL_COUNT == 9'd0) begin
            w_cnt_eff = 9'd1;
        end else if (AVL_COUNT > 9'd256) begin
            w_cnt_eff = 9'd256;
        end else begin
            w_cnt_eff = AVL_COUNT;
        end
    end

    assign w_accept = (r_state == IDLE) && AVL_BEGIN && (AVL_READ || AVL_WRITE);
    assign w_ridx   = r_addr + DEPTH_LOG2'(r_issue);
    assign AVL_WAIT = (r_state == RD_LAT) || (r_state == RD_BURST);

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_count_next = r_count;
        w_beat_next  = r_beat;
        w_issue_next = r_issue;
        w_lat_next   = r_lat;
        w_we         = 1'b0;
        w_re         = 1'b0;
        w_widx       = AVL_ADDRESS[DEPTH_LOG2-1:0];
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_addr_next  = AVL_ADDRESS[DEPTH_LOG2-1:0];
                    w_count_next = w_cnt_eff;
                    w_issue_next = 9'd0;
                    w_lat_next   = 4'd0;
                    w_beat_next  = 9'd0;
                    if (AVL_WRITE) begin
                        w_we = 1'b1;
                        if (w_cnt_eff != 9'd1) begin
                            w_state_next = WR_BURST;
                            w_beat_next  = 9'd1;
                        end
                    end else begin
                        w_state_next = RD_LAT;
                    end
                end
            end
            WR_BURST: begin
                w_widx = r_addr + DEPTH_LOG2'(r_beat);
                if (AVL_WRITE) begin
                    w_we = 1'b1;
                    if (r_beat == r_count - 9'd1) begin
                        w_state_next = IDLE;
                        w_beat_next  = 9'd0;
                    end else begin
                        w_beat_next = r_beat + 9'd1;
                    end
                end
            end
            RD_LAT: begin
                // Storage read plus output register: issue two edges ahead of the beat.
                w_re = (r_lat >= LAT_ISSUE) && (r_issue != r_count);
                if (r_lat == LAT_LAST) begin
                    w_state_next = RD_BURST;
                    w_lat_next   = 4'd0;
                    w_beat_next  = 9'd0;
                end else begin
                    w_lat_next = r_lat + 4'd1;
                end
            end
            RD_BURST: begin
                w_re = (r_issue != r_count);
                if (r_beat == r_count - 9'd1) begin
                    w_state_next = IDLE;
                    w_beat_next  = 9'd0;
                end else begin
                    w_beat_next = r_beat + 9'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (w_re) begin
            w_issue_next = r_issue + 9'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_count       <= '0;
            r_beat        <= '0;
            r_issue       <= '0;
            r_lat         <= '0;
            r_q_vld       <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_addr        <= w_addr_next;
            r_count       <= w_count_next;
            r_beat        <= w_beat_next;
            r_issue       <= w_issue_next;
            r_lat         <= w_lat_next;
            r_q_vld       <= w_re;
            r_rdata_valid <= r_q_vld;
            if (r_q_vld) begin
                r_rdata <= r_mem_q;
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[w_widx] <= AVL_WDATA;
        end
        r_mem_q <= r_mem[w_ridx];
    end

    assign AVL_RDATA       = r_rdata;
    assign AVL_RDATA_VALID = r_rdata_valid;
endmodule

// File: doc/avl_mem_responder.md
AVL_MEM_RESPONDER -- requirements
Module: avl_mem_responder

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set the data bus width.
REQ-002 Parameter ADDR_W, default 26, SHALL set the word-address width.
REQ-003 Parameter DEPTH_LOG2, default 8, SHALL set the internal storage size to 2^DEPTH_LOG2 words.
REQ-004 Parameter READ_LATENCY, default 3, legal range 2..15, SHALL set the cycles from read acceptance to the first valid beat.
REQ-005 Ports SHALL be exactly:
- CLK  in  1  sole clock; all logic rising-edge.
- RST_N  in  1  reset, asynchronous, active-low.
- AVL_ADDRESS  in  ADDR_W  burst start word address.
- AVL_BEGIN  in  1  burst-begin strobe.
- AVL_COUNT  in  9  burst length in beats.
- AVL_READ  in  1  read request.
- AVL_WRITE  in  1  write request or write beat.
- AVL_WDATA  in  DATA_W  write data.
- AVL_RDATA  out  DATA_W  read data.
- AVL_WAIT  out  1  wait-request; command or beat not accepted while high.
- AVL_RDATA_VALID  out  1  AVL_RDATA carries a valid beat.

Function
REQ-006 Block SHALL be the memory-side Avalon-MM burst responder, with four states: IDLE, WR_BURST, RD_LAT, RD_BURST.
REQ-007 Storage index SHALL be (start address + beat number) modulo 2^DEPTH_LOG2, so a burst crossing the top wraps to index 0.
REQ-008 Upper address bits above DEPTH_LOG2 SHALL be ignored.
REQ-009 AVL_COUNT = 0 SHALL be treated as 1, and AVL_COUNT > 256 SHALL be treated as 256; the count is latched at acceptance.
REQ-010 AVL_WAIT SHALL be 0 in IDLE and WR_BURST, and 1 in RD_LAT and RD_BURST.
REQ-011 A command SHALL be accepted only in IDLE, when AVL_BEGIN=1 and AVL_READ or AVL_WRITE is 1.
REQ-012 In IDLE, AVL_READ or AVL_WRITE without AVL_BEGIN SHALL be ignored.
REQ-013 If AVL_READ and AVL_WRITE are both 1 at acceptance, the write SHALL be serviced and the read dropped.
REQ-014 Write acceptance SHALL store AVL_WDATA as beat 0 in the same edge.
- Count 1: stay in IDLE.
- Otherwise: enter WR_BURST.
REQ-015 In WR_BURST, each cycle with AVL_WRITE=1 SHALL store one beat at the next index.
- Cycles with AVL_WRITE=0 SHALL stall without a write.
- AVL_BEGIN and AVL_READ SHALL be ignored.
- The edge storing the last beat SHALL return the block to IDLE.
REQ-016 Read acceptance at edge T SHALL latch the address and count, and enter RD_LAT.
REQ-017 AVL_RDATA_VALID SHALL be 1 for exactly N consecutive cycles, starting READ_LATENCY cycles after edge T.
- Beat i SHALL carry storage[(addr+i) mod depth].
- The state SHALL be RD_BURST during these cycles.
REQ-018 The block SHALL return to IDLE one cycle after the last valid beat; AVL_WAIT=0 in that cycle.
REQ-019 A read SHALL return data written by any write beat stored before the read was accepted.
REQ-020 AVL_RDATA SHALL hold its last value when AVL_RDATA_VALID=0.
REQ-021 No pipelined or overlapping reads SHALL occur; only one burst is outstanding at a time.

Reset
REQ-022 While RST_N=0, the block SHALL hold the following, independent of CLK:
- state IDLE;
- AVL_WAIT=0;
- AVL_RDATA_VALID=0;
- AVL_RDATA=0;
- beat and latency counters 0.
REQ-023 Storage contents SHALL NOT be cleared by reset.
REQ-024 Reset mid-burst SHALL abort the burst with no further beats stored or returned.
REQ-025 The first command after RST_N rises SHALL be accepted normally.

Verification
REQ-026 Write count 1, address 0x10, data 0xA5.. -> stored; AVL_WAIT stays 0; state stays IDLE.
REQ-027 Read count 1, address 0x10, accepted at edge T -> AVL_WAIT=1 from T+1; AVL_RDATA_VALID=1 for one cycle at T+3 with 0xA5..; AVL_WAIT=0 at T+4.
REQ-028 Write burst count 4 at address 0xFE, with AVL_WRITE low for one cycle after beat 1 -> four beats stored at indices 0xFE, 0xFF, 0x00, 0x01; read burst count 4 at 0xFE -> four consecutive valid beats in order.
REQ-029 AVL_READ=1 and AVL_WRITE=1 together with AVL_BEGIN=1 in IDLE -> write stored; AVL_RDATA_VALID never asserts.
REQ-030 RST_N dropped during beat 2 of a read burst of 8 -> AVL_RDATA_VALID=0 and AVL_WAIT=0 immediately; a new read of count 1 after release returns correct data at acceptance+3.
REQ-031 AVL_COUNT=0 read, then AVL_COUNT=300 read -> exactly 1 beat, then exactly 256 beats.
